x_post_crc_scanner: RTL and testbench

Readback CRC engine that feeds the post-configuration CRC error flag. It accepts a stream of 32-bit configuration readback words over a valid/ready handshake and runs a CRC-32C over one full scan of NUM_FRAMES × FRAME_WORDS words. It compares the result against a golden signature and raises a sticky CRCERROR on mismatch. The block sits directly upstream of the CRCERROR consumer, between the readback port controller and the error-reporting logic.

---
 rtl/x_post_crc_scanner.sv | 152 +++++++++++++++
 tb/tb_x_post_crc_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_post_crc_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : x_post_crc_scanner
//  Brief    : Readback CRC-32C scanner with golden compare and sticky CRCERROR.
//  Revision : 1.0  initial release
// ============================================================================
module x_post_crc_scanner #(
   parameter int          FRAME_WORDS = 41,
   parameter int          NUM_FRAMES  = 16,
   parameter logic [31:0] CRC_POLY    = 32'h1EDC6F41,
   parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_golden,
   input  logic        i_golden_load,
   input  logic        i_clr_err,
   input  logic [31:0] i_rb_data,
   input  logic        i_rb_valid,
   output logic        o_rb_ready,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_crc_value,
   output logic        o_golden_valid,
   output logic [7:0]  o_err_cnt,
   output logic        o_crcerror
);

   localparam int c_WORD_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int c_FRAME_W = (NUM_FRAMES  > 1) ? $clog2(NUM_FRAMES)  : 1;
   localparam logic [c_WORD_W-1:0]  c_LAST_WORD  = c_WORD_W'(FRAME_WORDS - 1);
   localparam logic [c_FRAME_W-1:0] c_LAST_FRAME = c_FRAME_W'(NUM_FRAMES - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;

   logic [1:0]           r_state;
   logic                 r_rb_ready;
   logic [31:0]          r_crc;
   logic [c_WORD_W-1:0]  r_word_cnt;
   logic [c_FRAME_W-1:0] r_frame_cnt;
   logic [31:0]          r_crc_value;
   logic [31:0]          r_golden;
   logic                 r_golden_valid;
   logic [7:0]           r_err_cnt;
   logic                 r_crcerror;
   logic                 r_done;

   logic        w_xfer;
   logic        w_last_word;
   logic        w_mismatch;
   logic [31:0] w_crc_next;

   // MSB-first bit-serial CRC unrolled across the whole word
   function automatic logic [31:0] f_crc_word(input logic [31:0] crc, input logic [31:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
      end
      return c;
   endfunction

   assign w_crc_next  = f_crc_word(r_crc, i_rb_data);
   assign w_xfer      = i_rb_valid & r_rb_ready;
   assign w_last_word = (r_word_cnt == c_LAST_WORD) && (r_frame_cnt == c_LAST_FRAME);
   assign w_mismatch  = (r_state == S_CHECK) && r_golden_valid && (r_crc != r_golden);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_rb_ready     <= 1'b0;
         r_crc          <= CRC_INIT;
         r_word_cnt     <= '0;
         r_frame_cnt    <= '0;
         r_crc_value    <= 32'h0;
         r_golden       <= 32'h0;
         r_golden_valid <= 1'b0;
         r_err_cnt      <= 8'h0;
         r_crcerror     <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_crc       <= CRC_INIT;
               r_word_cnt  <= '0;
               r_frame_cnt <= '0;
               if (i_start) begin
                  r_state    <= S_SCAN;
                  r_rb_ready <= 1'b1;
               end
            end
            S_SCAN: begin
               if (w_xfer) begin
                  r_crc <= w_crc_next;
                  if (r_word_cnt == c_LAST_WORD) begin
                     r_word_cnt  <= '0;
                     r_frame_cnt <= w_last_word ? '0 : r_frame_cnt + 1'b1;
                  end else begin
                     r_word_cnt <= r_word_cnt + 1'b1;
                  end
                  if (w_last_word) begin
                     r_state    <= S_CHECK;
                     r_rb_ready <= 1'b0;
                  end
               end
            end
            S_CHECK: begin
               r_crc_value <= r_crc;
               r_done      <= 1'b1;
               r_state     <= S_IDLE;
               if (!r_golden_valid) begin
                  r_golden       <= r_crc;
                  r_golden_valid <= 1'b1;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_rb_ready <= 1'b0;
            end
         endcase

         // a mismatch outranks a coincident clear
         if (w_mismatch) begin
            r_crcerror <= 1'b1;
            r_err_cnt  <= i_clr_err ? 8'd1 : ((r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1);
         end else if (i_clr_err) begin
            r_crcerror <= 1'b0;
            r_err_cnt  <= 8'h0;
         end

         // placed last so an explicit load overrides a same-cycle capture
         if (i_golden_load) begin
            r_golden       <= i_golden;
            r_golden_valid <= 1'b1;
         end
      end
   end

   assign o_rb_ready     = r_rb_ready;
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = r_done;
   assign o_crc_value    = r_crc_value;
   assign o_golden_valid = r_golden_valid;
   assign o_err_cnt      = r_err_cnt;
   assign o_crcerror     = r_crcerror;

endmodule
`default_nettype wire

// File: tb/tb_x_post_crc_scanner.sv
`default_nettype none
// Testbench for x_post_crc_scanner: directed scans, scoreboard checked on DONE.
module tb_x_post_crc_scanner;

   localparam int          FW   = 4;
   localparam int          NF   = 2;
   localparam int          NW   = FW * NF;
   localparam logic [31:0] POLY = 32'h1EDC6F41;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [31:0] i_golden = 32'h0;
   logic        i_golden_load = 1'b0;
   logic        i_clr_err = 1'b0;
   logic [31:0] i_rb_data = 32'h0;
   logic        i_rb_valid = 1'b0;
   logic        o_rb_ready;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_crc_value;
   logic        o_golden_valid;
   logic [7:0]  o_err_cnt;
   logic        o_crcerror;

   x_post_crc_scanner #(
      .FRAME_WORDS (FW),
      .NUM_FRAMES  (NF),
      .CRC_POLY    (POLY),
      .CRC_INIT    (INIT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (i_start),
      .i_golden       (i_golden),
      .i_golden_load  (i_golden_load),
      .i_clr_err      (i_clr_err),
      .i_rb_data      (i_rb_data),
      .i_rb_valid     (i_rb_valid),
      .o_rb_ready     (o_rb_ready),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_crc_value    (o_crc_value),
      .o_golden_valid (o_golden_valid),
      .o_err_cnt      (o_err_cnt),
      .o_crcerror     (o_crcerror)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] crc;
      logic        gv;
      logic        err;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] words[NW];

   // bench-side model of golden/error state
   logic [31:0] m_golden = 32'h0;
   logic        m_gv     = 1'b0;
   logic        m_err    = 1'b0;
   logic [7:0]  m_cnt    = 8'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_crc();
      logic [31:0] c;
      logic [31:0] d;
      logic        fb;
      c = INIT;
      for (int w = 0; w < NW; w++) begin
         d = words[w];
         for (int b = 0; b < 32; b++) begin
            fb = c[31] ^ d[31];
            c  = c << 1;
            if (fb) c = c ^ POLY;
            d  = d << 1;
         end
      end
      return c;
   endfunction

   always @(negedge clk) begin
      if (rst_n && o_done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: DONE seen with empty scoreboard");
         end else begin
            mon_e = sb.pop_front();
            chk("crc_value",    o_crc_value,           mon_e.crc);
            chk("golden_valid", {31'h0, o_golden_valid}, {31'h0, mon_e.gv});
            chk("crcerror",     {31'h0, o_crcerror},     {31'h0, mon_e.err});
            chk("err_cnt",      {24'h0, o_err_cnt},      {24'h0, mon_e.cnt});
         end
      end
   end

   task automatic set_words(input bit bad_word);
      for (int i = 0; i < NW; i++) words[i] = 32'(i + 1);
      if (bad_word) words[4] = 32'h00000006;
   endtask

   // Called and returns at posedge+1.
   task automatic run_scan(input bit stall, input bit clr_chk, input bit gld_chk,
                           input logic [31:0] gval, input bit start_mid, input bit chk_lat);
      logic [31:0] crc;
      logic        mism;
      logic [15:0] pat;
      logic        v;
      logic        xf;
      int          idx;
      int          cyc;
      int          guard;
      crc  = model_crc();
      mism = m_gv && (crc != m_golden);
      if (!m_gv) begin
         m_golden = crc;
         m_gv     = 1'b1;
      end
      if (mism) begin
         m_err = 1'b1;
         m_cnt = clr_chk ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
      end else if (clr_chk) begin
         m_err = 1'b0;
         m_cnt = 8'h0;
      end
      if (gld_chk) begin
         m_golden = gval;
         m_gv     = 1'b1;
      end
      sb.push_back('{crc: crc, gv: m_gv, err: m_err, cnt: m_cnt});

      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("busy_after_start",  {31'h0, o_busy},     32'h1);
      chk("ready_after_start", {31'h0, o_rb_ready}, 32'h1);

      pat   = 16'hB2D6;
      idx   = 0;
      cyc   = 0;
      guard = 0;
      while (idx < NW && guard < 200) begin
         v          = stall ? pat[cyc % 16] : 1'b1;
         i_rb_valid = v;
         i_rb_data  = v ? words[idx] : 32'hA5A5A5A5;
         i_start    = (start_mid && idx == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
         xf = v && o_rb_ready;
         @(posedge clk); #1;
         cyc++;
         guard++;
         if (xf) idx++;
      end
      i_rb_valid = 1'b0;
      i_start    = 1'b0;
      if (idx < NW) begin
         total++;
         bad++;
         $display("FAIL word_timeout: accepted %0d words, required %0d", idx, NW);
      end

      chk("ready_in_check", {31'h0, o_rb_ready}, 32'h0);
      i_clr_err     = clr_chk;
      i_golden_load = gld_chk;
      i_golden      = gval;
      @(posedge clk); #1;
      cyc++;
      i_clr_err     = 1'b0;
      i_golden_load = 1'b0;

      guard = 0;
      while (!o_done && guard < 20) begin
         @(posedge clk); #1;
         cyc++;
         guard++;
      end
      if (!o_done) begin
         total++;
         bad++;
         $display("FAIL done_timeout: DONE low after %0d cycles, required high", cyc);
      end else begin
         // START cycle + 8 word cycles + CHECK puts DONE in the 10th cycle
         if (chk_lat) chk("done_latency", 32'(cyc), 32'd9);
         chk("busy_after_done", {31'h0, o_busy}, 32'h0);
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},    {31'h0, o_rb_ready},     32'h0);
      chk({tag, "_busy"},     {31'h0, o_busy},         32'h0);
      chk({tag, "_done"},     {31'h0, o_done},         32'h0);
      chk({tag, "_crcval"},   o_crc_value,             32'h0);
      chk({tag, "_gvalid"},   {31'h0, o_golden_valid}, 32'h0);
      chk({tag, "_errcnt"},   {24'h0, o_err_cnt},      32'h0);
      chk({tag, "_crcerror"}, {31'h0, o_crcerror},     32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("reset");

      // valid while idle must not be accepted
      i_rb_valid = 1'b1;
      i_rb_data  = 32'h12345678;
      repeat (2) begin
         @(posedge clk); #1;
         chk("idle_ready", {31'h0, o_rb_ready}, 32'h0);
      end
      i_rb_valid = 1'b0;

      set_words(1'b0);
      run_scan(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);   // capture
      set_words(1'b1);
      run_scan(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);   // mismatch -> 1
      run_scan(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);   // mismatch -> 2
      set_words(1'b0);
      run_scan(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);   // stalled, matches
      set_words(1'b1);
      run_scan(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);   // clear vs mismatch

      i_clr_err = 1'b1;
      @(posedge clk); #1;
      i_clr_err = 1'b0;
      m_err = 1'b0;
      m_cnt = 8'h0;
      chk("clr_crcerror", {31'h0, o_crcerror}, 32'h0);
      chk("clr_errcnt",   {24'h0, o_err_cnt},  32'h0);

      set_words(1'b0);
      run_scan(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0); // old golden used
      run_scan(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);        // vs DEADBEEF

      for (int s = 0; s < 256; s++) begin
         run_scan(1'b0, 1'b0, 1'b0, 32'h0, (s == 100), 1'b0);
      end
      chk("sat_errcnt", {24'h0, o_err_cnt}, 32'd255);

      // asynchronous reset three words into a scan
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start    = 1'b0;
      i_rb_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_rb_data = words[i];
         @(posedge clk); #1;
      end
      i_rb_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      m_golden = 32'h0;
      m_gv     = 1'b0;
      m_err    = 1'b0;
      m_cnt    = 8'h0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_scan(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);   // fresh capture

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
